axi4s_uart_tx_arb: RTL and testbench

Packet-level round-robin arbiter that shares one UART transmitter byte stream between NUM_CH AXI4-Stream byte sources. It sits directly in front of axi4s_uart_tx and drives its tx_byte_* slave port. A grant is held from the first beat of a packet until its tlast beat, so packets from different sources never interleave on the serial line. Null beats (tkeep=0) are consumed locally, so the transmitter never stalls on them.

---
 rtl/axi4s_uart_pkg.sv | 32 +++
 rtl/axi4s_rr_arbiter.sv | 33 +++
 rtl/axi4s_uart_tx_arb.sv | 118 +++++++++++
 tb/tb_axi4s_uart_tx_arb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4s_uart_pkg.sv
// Shared types and helpers for the AXI4-Stream to UART-TX packet arbiter.
package axi4s_uart_pkg;

  localparam int unsigned MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    FORWARD = 2'd2
  } arb_state_t;

  // Round-robin search starting one past ptr, wrapping at num; returns {found, index}.
  function automatic logic [4:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [3:0]        ptr,
                                         input logic [4:0]        num);
    logic       found;
    logic [3:0] idx;
    logic [4:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= MAX_CH; i++) begin
      cand = 5'(ptr) + 5'(i);
      if (cand >= num) cand = cand - num;
      if (!found && (i <= 32'(num)) && req[cand[3:0]]) begin
        found = 1'b1;
        idx   = cand[3:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/axi4s_rr_arbiter.sv
// Round-robin pointer and combinational winner search for the packet arbiter.
module axi4s_rr_arbiter
  import axi4s_uart_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_CH-1:0]         req_i,
  input  logic                      update_i,
  output logic [$clog2(NUM_CH)-1:0] grant_o,
  output logic                      valid_o
);

  localparam int unsigned GW = $clog2(NUM_CH);

  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [4:0]    pick;

  always_comb begin
    pick     = rr_pick(MAX_CH'(req_i), 4'(rr_ptr_q), 5'(NUM_CH));
    valid_o  = pick[4];
    grant_o  = GW'(pick[3:0]);
    rr_ptr_d = update_i ? grant_o : rr_ptr_q;
  end

  // Pointer starts at the last channel so the first search begins at channel 0.
  always_ff @(posedge aclk) begin
    if (areset) rr_ptr_q <= GW'(NUM_CH - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/axi4s_uart_tx_arb.sv
// Packet-level round-robin arbiter feeding one UART transmitter byte stream.
// Optional channel header byte per packet: define AXI4S_UART_TX_ARB_HDR_EN.
module axi4s_uart_tx_arb
  import axi4s_uart_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter logic [7:0]  HDR_BASE = 8'h80
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_CH-1:0]         s_tvalid,
  output logic [NUM_CH-1:0]         s_tready,
  input  logic [NUM_CH*8-1:0]       s_tdata,
  input  logic [NUM_CH-1:0]         s_tkeep,
  input  logic [NUM_CH-1:0]         s_tlast,
  output logic                      tx_byte_tvalid,
  input  logic                      tx_byte_tready,
  output logic [7:0]                tx_byte_tdata,
  output logic                      tx_byte_tkeep,
  output logic [$clog2(NUM_CH)-1:0] grant,
  output logic                      busy
);

  localparam int unsigned GW = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > MAX_CH || HDR_BASE[3:0] != 4'h0) begin : g_bad_param
    $error("axi4s_uart_tx_arb: NUM_CH must be 2..16 and HDR_BASE[3:0] must be 0");
  end

  arb_state_t    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] arb_grant;
  logic          arb_valid;
  logic          arb_update;
  logic          g_valid, g_keep, g_last;
  logic [7:0]    g_data;

  axi4s_rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .aclk    (aclk),
    .areset  (areset),
    .req_i   (s_tvalid),
    .update_i(arb_update),
    .grant_o (arb_grant),
    .valid_o (arb_valid)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

`ifdef AXI4S_UART_TX_ARB_HDR_EN
  logic [7:0] hdr_q;

  always_ff @(posedge aclk) begin
    if (areset)          hdr_q <= '0;
    else if (arb_update) hdr_q <= HDR_BASE | 8'(arb_grant);
  end
`endif

  always_comb begin
    g_valid = s_tvalid[grant_q];
    g_keep  = s_tkeep[grant_q];
    g_last  = s_tlast[grant_q];
    g_data  = s_tdata[8*grant_q +: 8];
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    arb_update     = 1'b0;
    s_tready       = '0;
    tx_byte_tvalid = 1'b0;
    tx_byte_tdata  = '0;
    tx_byte_tkeep  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          arb_update = 1'b1;
          grant_d    = arb_grant;
`ifdef AXI4S_UART_TX_ARB_HDR_EN
          state_d    = HEADER;
`else
          state_d    = FORWARD;
`endif
        end
      end
`ifdef AXI4S_UART_TX_ARB_HDR_EN
      HEADER: begin
        tx_byte_tvalid = 1'b1;
        tx_byte_tkeep  = 1'b1;
        tx_byte_tdata  = hdr_q;
        if (tx_byte_tready) state_d = FORWARD;
      end
`endif
      FORWARD: begin
        tx_byte_tvalid = g_valid & g_keep;
        tx_byte_tkeep  = 1'b1;
        tx_byte_tdata  = g_data;
        // Null beats are acknowledged here without touching the transmitter.
        s_tready[grant_q] = g_keep ? tx_byte_tready : 1'b1;
        if (g_valid && (tx_byte_tready || !g_keep) && g_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_axi4s_uart_tx_arb.sv
// Scoreboard bench for axi4s_uart_tx_arb: per-channel beat queues, expected tx byte queue.
module tb_axi4s_uart_tx_arb;

  localparam int NCH = 4;
`ifdef AXI4S_UART_TX_ARB_HDR_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  logic             aclk = 1'b0;
  logic             areset = 1'b1;
  logic [NCH-1:0]   s_tvalid = '0;
  logic [NCH-1:0]   s_tready;
  logic [NCH*8-1:0] s_tdata = '0;
  logic [NCH-1:0]   s_tkeep = '0;
  logic [NCH-1:0]   s_tlast = '0;
  logic             tx_byte_tvalid;
  logic             tx_byte_tready = 1'b1;
  logic [7:0]       tx_byte_tdata;
  logic             tx_byte_tkeep;
  logic [1:0]       grant;
  logic             busy;

  axi4s_uart_tx_arb #(
    .NUM_CH  (NCH),
    .HDR_BASE(8'h80)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tdata       (s_tdata),
    .s_tkeep       (s_tkeep),
    .s_tlast       (s_tlast),
    .tx_byte_tvalid(tx_byte_tvalid),
    .tx_byte_tready(tx_byte_tready),
    .tx_byte_tdata (tx_byte_tdata),
    .tx_byte_tkeep (tx_byte_tkeep),
    .grant         (grant),
    .busy          (busy)
  );

  always #5 aclk = ~aclk;

  int          vecs = 0;
  int          errs = 0;
  int          tx_hs = 0;
  int          null_acks = 0;
  bit          rand_rdy = 1'b0;
  logic [9:0]  chq [NCH][$];   // {keep, last, data}
  logic [11:0] expq[$];        // {channel, byte}
  logic [NCH-1:0] hs = '0;
  bit          prev_pend = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pkt_start(input int ch);
`ifdef AXI4S_UART_TX_ARB_HDR_EN
    expq.push_back({4'(ch), 8'h80 | 8'(ch)});
`else
    if (ch < 0) $display("bad channel %0d", ch);
`endif
  endtask

  task automatic beat(input int ch, input logic [7:0] d, input logic k, input logic l);
    chq[ch].push_back({k, l, d});
    if (k) expq.push_back({4'(ch), d});
  endtask

  function automatic bit src_pending();
    bit p = 1'b0;
    for (int c = 0; c < NCH; c++) if (chq[c].size() != 0) p = 1'b1;
    return p;
  endfunction

  // Source driver: retire beats handshaken on the previous edge, present the next ones.
  always @(posedge aclk) begin
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (hs[c] && chq[c].size() != 0) void'(chq[c].pop_front());
      if (chq[c].size() != 0) begin
        s_tvalid[c]         = 1'b1;
        s_tkeep[c]          = chq[c][0][9];
        s_tlast[c]          = chq[c][0][8];
        s_tdata[8*c +: 8]   = chq[c][0][7:0];
      end else begin
        s_tvalid[c]         = 1'b0;
        s_tkeep[c]          = 1'b0;
        s_tlast[c]          = 1'b0;
        s_tdata[8*c +: 8]   = 8'h00;
      end
    end
    tx_byte_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compares every tx handshake against the scoreboard.
  always @(negedge aclk) begin
    logic [11:0] e;
    hs = s_tvalid & s_tready;
    if (!areset) begin
      if (prev_pend) begin
        check("hold_valid", tx_byte_tvalid, 1);
        check("hold_data", tx_byte_tdata, prev_data);
      end
      if (tx_byte_tvalid && tx_byte_tready) begin
        tx_hs++;
        if (expq.size() == 0) begin
          check("unexpected_byte", {24'h0, tx_byte_tdata}, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          check("tx_data", tx_byte_tdata, e[7:0]);
          check("tx_grant", grant, e[11:8]);
          check("tx_keep", tx_byte_tkeep, 1);
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (s_tvalid[c] && s_tready[c] && !s_tkeep[c]) begin
          null_acks++;
          check("null_no_tx", tx_byte_tvalid, 0);
        end
      end
      prev_pend = tx_byte_tvalid && !tx_byte_tready;
      prev_data = tx_byte_tdata;
    end else begin
      prev_pend = 1'b0;
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while (n < 3000 && (busy || expq.size() != 0 || src_pending())) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_expq_empty"}, expq.size(), 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_tx(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge aclk);
      if (tx_byte_tvalid && tx_byte_tready && tx_byte_tdata == d) ok = 1'b1;
    end
  endtask

  task automatic wait_ack(input int ch, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge aclk);
      if (s_tvalid[ch] && s_tready[ch]) ok = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge aclk);
    #2;
    areset = 1'b1;
    for (int c = 0; c < NCH; c++) chq[c].delete();
    expq.delete();
    @(posedge aclk);
    #2;
    areset = 1'b0;
  endtask

  initial begin
    bit ok;
    int base;
    repeat (3) @(posedge aclk);
    #2;
    areset = 1'b0;
    @(negedge aclk);
    check("rst_tready", s_tready, 0);
    check("rst_tvalid", tx_byte_tvalid, 0);
    check("rst_tdata", tx_byte_tdata, 0);
    check("rst_tkeep", tx_byte_tkeep, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);

    // Single channel 2 packet; busy drops one cycle after the tlast handshake.
    pkt_start(2);
    beat(2, 8'h41, 1, 0);
    beat(2, 8'h42, 1, 0);
    beat(2, 8'h43, 1, 1);
    wait_tx(8'h43, ok);
    check("t1_last_seen", ok, 1);
    check("t1_busy_at_last", busy, 1);
    @(negedge aclk);
    check("t1_busy_fall", busy, 0);
    check("t1_grant_held", grant, 2);
    drain("t1");

    // All channels requesting: order 0,1,2,3,0 from reset.
    pulse_reset();
    pkt_start(0); beat(0, 8'h01, 1, 0); beat(0, 8'h02, 1, 1);
    pkt_start(1); beat(1, 8'h11, 1, 0); beat(1, 8'h12, 1, 1);
    pkt_start(2); beat(2, 8'h21, 1, 0); beat(2, 8'h22, 1, 1);
    pkt_start(3); beat(3, 8'h31, 1, 0); beat(3, 8'h32, 1, 1);
    pkt_start(0); beat(0, 8'h03, 1, 0); beat(0, 8'h04, 1, 1);
    drain("t2");

    // Null beat inside a packet on channel 1.
    base = null_acks;
    pkt_start(1);
    beat(1, 8'h11, 1, 0);
    beat(1, 8'h5A, 0, 0);
    beat(1, 8'h12, 1, 1);
    drain("t3");
    check("t3_null_acks", null_acks - base, 1);

    // Packet made of a single null beat on channel 0.
    base = tx_hs;
    pkt_start(0);
    beat(0, 8'h77, 0, 1);
    wait_ack(0, ok);
    check("t4_ack_seen", ok, 1);
    check("t4_no_tvalid", tx_byte_tvalid, 0);
    check("t4_busy_at_ack", busy, 1);
    @(negedge aclk);
    check("t4_idle_after", busy, 0);
    drain("t4");
    check("t4_tx_count", tx_hs - base, HDR_BYTES);

    // 16-byte packet under random backpressure.
    rand_rdy = 1'b1;
    base = tx_hs;
    pkt_start(1);
    for (int i = 0; i < 16; i++) beat(1, 8'hA0 + 8'(i), 1, (i == 15));
    drain("t5");
    check("t5_tx_count", tx_hs - base, 16 + HDR_BYTES);
    rand_rdy = 1'b0;

    // Reset mid-packet on channel 3, then fresh arbitration from channel 0.
    pkt_start(3);
    for (int i = 0; i < 8; i++) beat(3, 8'hB0 + 8'(i), 1, (i == 7));
    base = tx_hs;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge aclk);
      if (tx_hs >= base + 2) ok = 1'b1;
    end
    check("t6_mid_packet", ok, 1);
    check("t6_grant_pre", grant, 3);
    @(posedge aclk);
    #2;
    areset = 1'b1;
    for (int c = 0; c < NCH; c++) chq[c].delete();
    expq.delete();
    @(negedge aclk);
    @(negedge aclk);
    check("t6_rst_tready", s_tready, 0);
    check("t6_rst_tvalid", tx_byte_tvalid, 0);
    check("t6_rst_tdata", tx_byte_tdata, 0);
    check("t6_rst_tkeep", tx_byte_tkeep, 0);
    check("t6_rst_grant", grant, 0);
    check("t6_rst_busy", busy, 0);
    @(posedge aclk);
    #2;
    areset = 1'b0;
    pkt_start(0); beat(0, 8'hC0, 1, 1);
    pkt_start(1); beat(1, 8'hC1, 1, 1);
    pkt_start(2); beat(2, 8'hC2, 1, 1);
    pkt_start(3); beat(3, 8'hC3, 1, 1);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", errs);
    $fatal(1);
  end

endmodule
